// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store and writeback-select stage with request/grant/response data bus
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] result,
    input  logic [31:0] Data_store,
    input  logic [31:0] PC_4,
    input  logic [31:0] immOut,
    input  logic [5:0]  opcode,
    input  logic [1:0]  whb,
    input  logic        su,
    input  logic [1:0]  wos,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic        misaligned
);
    localparam logic [5:0] OP_LOAD  = 6'b000011;
    localparam logic [5:0] OP_STORE = 6'b100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_d;

    logic [31:0] result_q, pc4_q, imm_q;
    logic [1:0]  whb_q, wos_q;
    logic        su_q, store_q;

    logic        is_load_in, is_store_in, mis_in, capture;
    logic        store_now, fault_now;
    logic [31:0] st_wdata, rd_shift, ld_data, wb_d;
    logic [3:0]  st_wstrb;

    assign in_ready    = (state == IDLE);
    assign capture     = (state == IDLE) && in_valid;
    assign is_load_in  = (opcode == OP_LOAD);
    assign is_store_in = (opcode == OP_STORE);
    assign mis_in      = (is_load_in || is_store_in) &&
                         (((whb == 2'b01) && result[0]) || (whb[1] && (result[1:0] != 2'b00)));
    assign store_now   = (state == IDLE) ? is_store_in : store_q;
    assign fault_now   = (state == IDLE) && mis_in;

    always_comb begin
        st_wdata = Data_store;
        st_wstrb = 4'b1111;
        case (whb)
            2'b00: begin
                st_wdata = {4{Data_store[7:0]}};
                st_wstrb = 4'b0001 << result[1:0];
            end
            2'b01: begin
                st_wdata = {2{Data_store[15:0]}};
                st_wstrb = 4'b0011 << {result[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_shift = dmem_rdata >> {result_q[1:0], 3'b000};
        case (whb_q)
            2'b00:   ld_data = {{24{su_q & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   ld_data = {{16{su_q & rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
    end

    // Non-memory ops retire straight from IDLE, loads from WAIT; stores/faults write back zero.
    always_comb begin
        wb_d = 32'd0;
        if (state == IDLE && !is_store_in && !mis_in) begin
            case (wos)
                2'b00:   wb_d = result;
                2'b10:   wb_d = PC_4;
                2'b11:   wb_d = immOut;
                default: wb_d = 32'd0;
            endcase
        end else if (state == WAIT) begin
            case (wos_q)
                2'b00:   wb_d = result_q;
                2'b01:   wb_d = ld_data;
                2'b10:   wb_d = pc4_q;
                default: wb_d = imm_q;
            endcase
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (in_valid)
                      state_d = ((is_load_in || is_store_in) && !mis_in) ? REQ : DONE;
            REQ:  if (dmem_gnt) state_d = store_q ? DONE : WAIT;
            WAIT: if (dmem_rvalid) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            result_q   <= 32'd0;
            pc4_q      <= 32'd0;
            imm_q      <= 32'd0;
            whb_q      <= 2'b00;
            wos_q      <= 2'b00;
            su_q       <= 1'b0;
            store_q    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_wstrb <= 4'b0000;
            wb_valid   <= 1'b0;
            wb_en      <= 1'b0;
            wb_data    <= 32'd0;
            misaligned <= 1'b0;
        end else begin
            state <= state_d;
            if (capture) begin
                result_q <= result;
                pc4_q    <= PC_4;
                imm_q    <= immOut;
                whb_q    <= whb;
                wos_q    <= wos;
                su_q     <= su;
                store_q  <= is_store_in;
                if (state_d == REQ) begin
                    dmem_addr  <= {result[31:2], 2'b00};
                    dmem_wdata <= is_store_in ? st_wdata : 32'd0;
                    dmem_wstrb <= is_store_in ? st_wstrb : 4'b0000;
                end
            end
            dmem_req   <= (state_d == REQ);
            dmem_we    <= (state_d == REQ) && store_now;
            wb_valid   <= (state_d == DONE);
            wb_en      <= (state_d == DONE) && !store_now && !fault_now;
            misaligned <= (state_d == DONE) && fault_now;
            if (state_d == DONE) wb_data <= wb_d;
        end
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store and writeback-select stage of the unpipelined RISC-V core, sitting directly after the execute stage. It consumes the execute stage's result, store data, size and sign controls, writeback select and opcode. It performs aligned byte, half or word accesses on a request/grant/response data-memory bus and returns one writeback word per instruction. It also flags misaligned accesses instead of issuing them.

## Interface
- No parameters.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  execute-stage outputs valid this cycle
- in_ready  out  1  unit idle, accepts an instruction
- result  in  32  ALU result; memory byte address for loads and stores
- Data_store  in  32  rs2 value for stores
- PC_4  in  32  PC+4 for jal/jalr writeback
- immOut  in  32  immediate for lui writeback
- opcode  in  6  opcode[5:0]: 6'b000011 = load, 6'b100011 = store, anything else = non-memory
- whb  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- su  in  1  1 = sign-extend load data, 0 = zero-extend
- wos  in  2  writeback select: 00 result, 01 load data, 10 PC_4, 11 immOut
- dmem_req  out  1  bus request, held until granted
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address: {result[31:2], 2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables; 0000 on reads
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data word
- wb_valid  out  1  one-cycle pulse: instruction retired
- wb_en  out  1  register write enable, qualified by wb_valid
- wb_data  out  32  writeback value
- misaligned  out  1  qualified by wb_valid: access was misaligned and not issued

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. in_ready = (state == IDLE).
- IDLE with in_valid: capture all inputs.
  - Non-memory opcode → DONE.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0) → DONE with fault set.
  - Aligned load or store → REQ.
- REQ: dmem_req=1 and address/data/strobes stable until dmem_gnt.
  - Store granted → DONE.
  - Load granted → WAIT.
- WAIT: on dmem_rvalid, latch the extracted load data → DONE. dmem_rvalid arriving in the same cycle as gnt is ignored; the responder returns data at least one cycle after grant.
- DONE: wb_valid=1 for exactly one cycle → IDLE.
- Store strobes and data:
  - byte: wstrb = 0001 << addr[1:0], wdata = {4{Data_store[7:0]}}
  - half: wstrb = 0011 << {addr[1],1'b0}, wdata = {2{Data_store[15:0]}}
  - word: wstrb = 1111, wdata = Data_store
- Load extraction: shift dmem_rdata right by addr[1:0]*8, take 8/16/32 bits, then extend per su. su is ignored for word loads.
- Writeback:
  - wb_en=1 only for non-store, non-faulting instructions.
  - wb_data chosen by wos.
  - wos=01 on a non-load returns 0.
  - Stores and faults drive wb_data=0, wb_en=0.
- misaligned=1 only on the DONE pulse of a faulting load or store. No bus activity occurs for it.

## Timing
- Reset (rst low, asynchronous):
  - State → IDLE.
  - dmem_req, dmem_we, wb_valid, wb_en, misaligned → 0.
  - dmem_addr, dmem_wdata, wb_data → 0; dmem_wstrb → 0000.
  - in_ready=1 after release.
- Reset mid-access drops dmem_req immediately. A pending response is discarded, and no wb_valid is produced for the aborted instruction.
- Latency from the capture edge (cycle N):
  - Non-memory or misaligned: wb_valid in N+1.
  - Store granted in its first REQ cycle: dmem_req in N+1, wb_valid in N+2.
  - Load with gnt in N+1 and rvalid in N+2: wb_valid in N+3.
  - Each extra cycle of gnt or rvalid stall adds one cycle.
- Only one instruction is in flight at a time. in_valid outside IDLE is ignored, and the upstream stage holds its inputs.
- Outputs are registered. The only combinational output is in_ready.

## Test plan
- Non-memory: opcode=6'b110011, result=0x0000_0055, wos=00 → wb_valid at N+1, wb_en=1, wb_data=0x0000_0055, dmem_req never asserted.
- Signed byte load: result=0x0000_1003, whb=00, su=1, rdata=0x80AB_CDEF, gnt with 2-cycle stall → dmem_addr=0x0000_1000, wstrb=0000, wb_data=0xFFFF_FF80, wb_valid at N+5.
- Half store: result=0x0000_2002, whb=01, Data_store=0x1234_BEEF → dmem_we=1, wstrb=1100, wdata=0xBEEF_BEEF, wb_en=0.
- Misaligned word load: result=0x0000_3001, whb=10 → no dmem_req, wb_valid at N+1 with misaligned=1, wb_en=0.
- Jal writeback plus backpressure: wos=10, PC_4=0x0000_0104, in_valid held during busy → wb_data=0x0000_0104, a second instruction is captured only when in_ready=1.
- Reset during WAIT: load in flight, rst low for one cycle, rvalid arrives afterward → dmem_req=0 immediately, no wb_valid, unit returns to IDLE.
